// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding the single-cycle core. Owns the fetch PC,
// issues word reads to instruction memory over a req/ack handshake and buffers
// returned {pc, instruction} pairs in a small FIFO presented with valid/ready.
// A redirect from the core flushes the FIFO and abandons any in-flight read.
//
// Ports
//   clk          system clock, all state on rising edge
//   nrst         asynchronous active-low reset
//   imem_req     read request to instruction memory
//   imem_addr    word-aligned read address (held until imem_ack)
//   imem_ack     memory accepts request, imem_rdata valid same cycle
//   imem_rdata   instruction word returned by memory
//   instruction  FIFO head instruction (0 when empty)
//   instr_pc     PC of FIFO head (0 when empty)
//   instr_valid  FIFO non-empty
//   instr_ready  core consumes head when instr_valid & instr_ready
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch PC, bits [1:0] forced to 0
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        nrst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int            PW   = $clog2(DEPTH);
   localparam int            CW   = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state_q;
   logic [31:0]   fetch_pc_q;
   logic [31:0]   drop_addr_q;
   logic [31:0]   pc_mem_q  [DEPTH];
   logic [31:0]   ins_mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [CW-1:0] cnt_after_w;
   logic          push_w;
   logic          pop_w;
   logic [31:0]   redir_pc_w;

   assign redir_pc_w  = redirect_pc & 32'hFFFF_FFFC;
   assign instr_valid = (count_q != '0);
   assign pop_w       = instr_valid & instr_ready;
   // A response that coincides with a redirect belongs to the old stream.
   assign push_w      = (state_q == WAIT) & imem_ack & ~redirect;
   // Occupancy after this cycle's push, used to decide whether to keep fetching.
   assign cnt_after_w = count_q + CW'(1) - CW'(pop_w);

   always_comb begin
      count_d = count_q;
      if (redirect)
         count_d = '0;
      else
         count_d = count_q + CW'(push_w) - CW'(pop_w);
   end

   assign imem_req    = (state_q == WAIT) || (state_q == DROP);
   // In DROP the abandoned address must stay on the bus until memory acks it.
   assign imem_addr   = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
   assign instruction = instr_valid ? ins_mem_q[rd_ptr_q] : '0;
   assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q]  : '0;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         drop_addr_q <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         count_q <= count_d;
         if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_w)  rd_ptr_q <= rd_ptr_q + PW'(1);
         end

         case (state_q)
            IDLE: begin
               if (redirect)
                  fetch_pc_q <= redir_pc_w;
               else if (count_q < FULL)
                  state_q <= WAIT;
            end
            WAIT: begin
               if (redirect) begin
                  fetch_pc_q <= redir_pc_w;
                  if (imem_ack) begin
                     state_q <= IDLE;
                  end else begin
                     drop_addr_q <= fetch_pc_q;
                     state_q     <= DROP;
                  end
               end else if (imem_ack) begin
                  fetch_pc_q <= fetch_pc_q + 32'd4;
                  if (cnt_after_w >= FULL) state_q <= IDLE;
               end
            end
            DROP: begin
               if (redirect) fetch_pc_q <= redir_pc_w;
               if (imem_ack) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // FIFO payload carries no reset; outputs are gated by instr_valid.
   always_ff @(posedge clk) begin
      if (push_w) begin
         pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
         ins_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

endmodule
